corridor_phase_scheduler: RTL and testbench

//  Sequences signal phases for both intersections (A = S10th, B = S11th) from one 1 Hz tick.
//  B lags A by a fixed offset (green wave). Latches pedestrian requests per intersection and

---
 rtl/traffic_pkg.sv | 32 +++
 rtl/phase_seq.sv | 124 ++++++++++++
 rtl/corridor_phase_scheduler.sv | 85 ++++++++
 tb/tb_corridor_phase_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase codes, widths and phase helpers for the corridor scheduler
package traffic_pkg;

    localparam int PHASE_W = 3;
    localparam int SEC_W   = 6;

    typedef enum logic [PHASE_W-1:0] {
        NRTH_GRN    = 3'd0,
        NRTH_YLW    = 3'd1,
        RED_TO_WEST = 3'd2,
        WEST_GRN    = 3'd3,
        WEST_YLW    = 3'd4,
        RED_TO_NRTH = 3'd5
    } phase_e;

    // Fixed ring 0>1>2>3>4>5>0; codes 6/7 never reach here (caught as illegal first).
    function automatic phase_e next_phase(input phase_e p);
        case (p)
            NRTH_GRN:    return NRTH_YLW;
            NRTH_YLW:    return RED_TO_WEST;
            RED_TO_WEST: return WEST_GRN;
            WEST_GRN:    return WEST_YLW;
            WEST_YLW:    return RED_TO_NRTH;
            default:     return NRTH_GRN;
        endcase
    endfunction

    function automatic logic is_green(input phase_e p);
        return (p == NRTH_GRN) || (p == WEST_GRN);
    endfunction

endpackage

// File: rtl/phase_seq.sv
// rtl/phase_seq.sv - one intersection: phase FSM, second counter, walk timer, ped pend, early end
//  clk        in   system clock
//  reset      in   synchronous, active-high
//  tick       in   qualified one-second strobe (already gated while held)
//  rise_nrth  in   north button rising edge
//  rise_west  in   west button rising edge
//  phase      out  current phase code
//  sec_left   out  seconds remaining in current phase
//  walk       out  {west,nrth} walk
//  pend       out  {west,nrth} pending requests
module phase_seq
    import traffic_pkg::*;
#(
    parameter int GRN_SEC     = 20,
    parameter int MIN_GRN_SEC = 8,
    parameter int YLW_SEC     = 3,
    parameter int ALLRED_SEC  = 1,
    parameter int WALK_SEC    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               rise_nrth,
    input  logic               rise_west,
    output logic [PHASE_W-1:0] phase,
    output logic [SEC_W-1:0]   sec_left,
    output logic [1:0]         walk,
    output logic [1:0]         pend
);

    phase_e             phase_q, phase_d;
    logic [SEC_W-1:0]   cnt_q, cnt_d;
    logic [SEC_W-1:0]   elapsed_q, elapsed_d;
    logic [SEC_W-1:0]   wcnt_q, wcnt_d;
    logic [1:0]         walk_q, walk_d;
    logic [1:0]         pend_q, pend_d;
    logic               cross_pend;
    logic               early_end;
    phase_e             nxt;

    function automatic logic [SEC_W-1:0] duration(input phase_e p);
        case (p)
            NRTH_GRN, WEST_GRN: return SEC_W'(GRN_SEC);
            NRTH_YLW, WEST_YLW: return SEC_W'(YLW_SEC);
            default:            return SEC_W'(ALLRED_SEC);
        endcase
    endfunction

    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        elapsed_d = elapsed_q;
        wcnt_d    = wcnt_q;
        walk_d    = walk_q;
        pend_d    = pend_q;
        nxt       = next_phase(phase_q);

        cross_pend = ((phase_q == NRTH_GRN) && pend_q[1]) || ((phase_q == WEST_GRN) && pend_q[0]);
        // The tick being processed counts as elapsed, so the green ends on the
        // tick that brings it to the floor.
        early_end  = cross_pend && (elapsed_q >= SEC_W'(MIN_GRN_SEC - 1));

        // A press is ignored only while this intersection is walking that direction.
        if (rise_nrth && !walk_q[0]) pend_d[0] = 1'b1;
        if (rise_west && !walk_q[1]) pend_d[1] = 1'b1;

        if (phase_q > RED_TO_NRTH) begin
            phase_d   = RED_TO_NRTH;
            cnt_d     = SEC_W'(ALLRED_SEC);
            elapsed_d = '0;
            walk_d    = '0;
        end else if (tick) begin
            if (walk_q != 2'b00) begin
                if (wcnt_q <= SEC_W'(1)) walk_d = 2'b00;
                else                     wcnt_d = wcnt_q - SEC_W'(1);
            end

            if ((cnt_q <= SEC_W'(1)) || early_end) begin
                phase_d   = nxt;
                cnt_d     = duration(nxt);
                elapsed_d = '0;
                if (is_green(phase_q)) walk_d = 2'b00;
                // Grant on green entry; a press arriving on this very edge counts.
                if (nxt == NRTH_GRN && (pend_q[0] || rise_nrth)) begin
                    walk_d    = 2'b01;
                    wcnt_d    = SEC_W'(WALK_SEC);
                    pend_d[0] = 1'b0;
                end
                if (nxt == WEST_GRN && (pend_q[1] || rise_west)) begin
                    walk_d    = 2'b10;
                    wcnt_d    = SEC_W'(WALK_SEC);
                    pend_d[1] = 1'b0;
                end
            end else begin
                cnt_d = cnt_q - SEC_W'(1);
                if (is_green(phase_q) && (elapsed_q != '1)) elapsed_d = elapsed_q + SEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= RED_TO_NRTH;
            cnt_q     <= SEC_W'(ALLRED_SEC);
            elapsed_q <= '0;
            wcnt_q    <= '0;
            walk_q    <= '0;
            pend_q    <= '0;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            elapsed_q <= elapsed_d;
            wcnt_q    <= wcnt_d;
            walk_q    <= walk_d;
            pend_q    <= pend_d;
        end
    end

    assign phase    = phase_q;
    assign sec_left = cnt_q;
    assign walk     = walk_q;
    assign pend     = pend_q;

endmodule

// File: rtl/corridor_phase_scheduler.sv
// rtl/corridor_phase_scheduler.sv - two-intersection green-wave phase scheduler
//  clk_50_mhz    in   system clock
//  reset         in   synchronous, active-high
//  tick_1hz      in   one-cycle 1 Hz strobe
//  ped_req_nrth  in   debounced north button level
//  ped_req_west  in   debounced west button level
//  phase_a/b     out  phase codes for A and B
//  walk_a/b      out  {west,nrth} walks
//  ped_pend      out  {b_west,b_nrth,a_west,a_nrth}
//  sec_left_a    out  seconds remaining in A's phase
module corridor_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GRN_SEC     = 20,
    parameter int MIN_GRN_SEC = 8,
    parameter int YLW_SEC     = 3,
    parameter int ALLRED_SEC  = 1,
    parameter int WALK_SEC    = 8,
    parameter int OFFSET_SEC  = 4
) (
    input  logic               clk_50_mhz,
    input  logic               reset,
    input  logic               tick_1hz,
    input  logic               ped_req_nrth,
    input  logic               ped_req_west,
    output logic [PHASE_W-1:0] phase_a,
    output logic [PHASE_W-1:0] phase_b,
    output logic [1:0]         walk_a,
    output logic [1:0]         walk_b,
    output logic [3:0]         ped_pend,
    output logic [SEC_W-1:0]   sec_left_a
);

    logic             nrth_prev_q, nrth_prev_d;
    logic             west_prev_q, west_prev_d;
    logic [SEC_W-1:0] offset_q, offset_d;
    logic             rise_nrth, rise_west;
    logic             tick_b;
    logic [1:0]       pend_a, pend_b;
    logic [SEC_W-1:0] sec_left_b_unused;

    always_comb begin
        nrth_prev_d = ped_req_nrth;
        west_prev_d = ped_req_west;
        offset_d    = offset_q;
        rise_nrth   = ped_req_nrth & ~nrth_prev_q;
        rise_west   = ped_req_west & ~west_prev_q;
        // B sees no ticks until the offset has run out, freezing it in all-red.
        tick_b      = tick_1hz && (offset_q == '0);
        if (tick_1hz && (offset_q != '0)) offset_d = offset_q - SEC_W'(1);
    end

    always_ff @(posedge clk_50_mhz) begin
        if (reset) begin
            nrth_prev_q <= 1'b0;
            west_prev_q <= 1'b0;
            offset_q    <= SEC_W'(OFFSET_SEC);
        end else begin
            nrth_prev_q <= nrth_prev_d;
            west_prev_q <= west_prev_d;
            offset_q    <= offset_d;
        end
    end

    phase_seq #(
        .GRN_SEC(GRN_SEC), .MIN_GRN_SEC(MIN_GRN_SEC), .YLW_SEC(YLW_SEC),
        .ALLRED_SEC(ALLRED_SEC), .WALK_SEC(WALK_SEC)
    ) u_seq_a (
        .clk(clk_50_mhz), .reset(reset), .tick(tick_1hz),
        .rise_nrth(rise_nrth), .rise_west(rise_west),
        .phase(phase_a), .sec_left(sec_left_a), .walk(walk_a), .pend(pend_a)
    );

    phase_seq #(
        .GRN_SEC(GRN_SEC), .MIN_GRN_SEC(MIN_GRN_SEC), .YLW_SEC(YLW_SEC),
        .ALLRED_SEC(ALLRED_SEC), .WALK_SEC(WALK_SEC)
    ) u_seq_b (
        .clk(clk_50_mhz), .reset(reset), .tick(tick_b),
        .rise_nrth(rise_nrth), .rise_west(rise_west),
        .phase(phase_b), .sec_left(sec_left_b_unused), .walk(walk_b), .pend(pend_b)
    );

    assign ped_pend = {pend_b, pend_a};

endmodule

// File: tb/tb_corridor_phase_scheduler.sv
// tb/tb_corridor_phase_scheduler.sv - directed self-checking bench for corridor_phase_scheduler
module tb_corridor_phase_scheduler;

    logic       clk_50_mhz = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       ped_req_nrth = 1'b0;
    logic       ped_req_west = 1'b0;
    logic [2:0] phase_a, phase_b;
    logic [1:0] walk_a, walk_b;
    logic [3:0] ped_pend;
    logic [5:0] sec_left_a;

    int tests = 0;
    int fails = 0;

    always #10 clk_50_mhz = ~clk_50_mhz;

    corridor_phase_scheduler #(
        .GRN_SEC(5), .MIN_GRN_SEC(3), .YLW_SEC(2),
        .ALLRED_SEC(1), .WALK_SEC(2), .OFFSET_SEC(2)
    ) dut (
        .clk_50_mhz(clk_50_mhz), .reset(reset), .tick_1hz(tick_1hz),
        .ped_req_nrth(ped_req_nrth), .ped_req_west(ped_req_west),
        .phase_a(phase_a), .phase_b(phase_b), .walk_a(walk_a), .walk_b(walk_b),
        .ped_pend(ped_pend), .sec_left_a(sec_left_a)
    );

    // Undisturbed timeline: 5 for 1 tick, then 0(5) 1(2) 2(1) 3(5) 4(2) 5(1) repeating.
    function automatic int exp_ph(input int k);
        int t;
        if (k <= 0) return 5;
        t = (k - 1) % 16;
        if (t < 5)  return 0;
        if (t < 7)  return 1;
        if (t < 8)  return 2;
        if (t < 13) return 3;
        if (t < 15) return 4;
        return 5;
    endfunction

    function automatic int exp_sl(input int k);
        int t;
        if (k <= 0) return 1;
        t = (k - 1) % 16;
        if (t < 5)  return 5 - t;
        if (t < 7)  return 7 - t;
        if (t < 8)  return 1;
        if (t < 13) return 13 - t;
        if (t < 15) return 15 - t;
        return 1;
    endfunction

    task automatic do_tick();
        @(negedge clk_50_mhz); tick_1hz = 1'b1;
        @(negedge clk_50_mhz); tick_1hz = 1'b0;
    endtask

    task automatic press_nrth();
        @(negedge clk_50_mhz); ped_req_nrth = 1'b1;
        @(negedge clk_50_mhz); ped_req_nrth = 1'b0;
    endtask

    task automatic press_west();
        @(negedge clk_50_mhz); ped_req_west = 1'b1;
        @(negedge clk_50_mhz); ped_req_west = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk_50_mhz); reset = 1'b1;
        @(negedge clk_50_mhz); reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_50_mhz);
        tick_1hz = 1'b1;
        @(negedge clk_50_mhz); tick_1hz = 1'b0; reset = 1'b0;
        @(negedge clk_50_mhz);
        tests++; if (phase_a !== 3'd5) begin fails++; $display("FAIL reset_phase_a got %0d want 5", phase_a); end
        tests++; if (phase_b !== 3'd5) begin fails++; $display("FAIL reset_phase_b got %0d want 5", phase_b); end
        tests++; if (sec_left_a !== 6'd1) begin fails++; $display("FAIL reset_sec_left got %0d want 1", sec_left_a); end
        tests++; if ({walk_b, walk_a} !== 4'b0) begin fails++; $display("FAIL reset_walk got %b want 0000", {walk_b, walk_a}); end
        tests++; if (ped_pend !== 4'b0) begin fails++; $display("FAIL reset_pend got %b want 0000", ped_pend); end
    endtask

    task automatic test_cycle();
        apply_reset();
        for (int k = 1; k <= 34; k++) begin
            do_tick();
            tests++; if (phase_a !== 3'(exp_ph(k))) begin fails++; $display("FAIL cycle_phase_a k=%0d got %0d want %0d", k, phase_a, exp_ph(k)); end
            tests++; if (sec_left_a !== 6'(exp_sl(k))) begin fails++; $display("FAIL cycle_sec_a k=%0d got %0d want %0d", k, sec_left_a, exp_sl(k)); end
            tests++; if (phase_b !== 3'(exp_ph(k - 2))) begin fails++; $display("FAIL cycle_phase_b k=%0d got %0d want %0d", k, phase_b, exp_ph(k - 2)); end
        end
    endtask

    task automatic test_north_ped();
        int pa [10];
        int pb [10];
        int wa [10];
        int wb [10];
        int pp [10];
        pa = '{3, 3, 4, 4, 5, 0, 0, 0, 0, 0};
        pb = '{2, 3, 3, 3, 4, 4, 5, 0, 0, 0};
        wa = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        wb = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        pp = '{5, 5, 5, 5, 5, 4, 4, 0, 0, 0};
        apply_reset();
        repeat (9) do_tick();
        tests++; if (phase_a !== 3'd3) begin fails++; $display("FAIL north_pre_phase got %0d want 3", phase_a); end
        press_nrth();
        tests++; if (ped_pend !== 4'b0101) begin fails++; $display("FAIL north_latch got %b want 0101", ped_pend); end
        for (int i = 0; i < 10; i++) begin
            do_tick();
            tests++; if (phase_a !== 3'(pa[i])) begin fails++; $display("FAIL north_phase_a k=%0d got %0d want %0d", i + 10, phase_a, pa[i]); end
            tests++; if (phase_b !== 3'(pb[i])) begin fails++; $display("FAIL north_phase_b k=%0d got %0d want %0d", i + 10, phase_b, pb[i]); end
            tests++; if (walk_a !== 2'(wa[i])) begin fails++; $display("FAIL north_walk_a k=%0d got %b want %0d", i + 10, walk_a, wa[i]); end
            tests++; if (walk_b !== 2'(wb[i])) begin fails++; $display("FAIL north_walk_b k=%0d got %b want %0d", i + 10, walk_b, wb[i]); end
            tests++; if (ped_pend !== 4'(pp[i])) begin fails++; $display("FAIL north_pend k=%0d got %b want %0d", i + 10, ped_pend, pp[i]); end
            if (i == 2) begin
                tests++; if (sec_left_a !== 6'd2) begin fails++; $display("FAIL north_early_sec got %0d want 2", sec_left_a); end
            end
        end
    endtask

    task automatic test_west_early();
        int pa [6];
        pa = '{0, 0, 1, 1, 2, 3};
        apply_reset();
        do_tick();
        press_west();
        tests++; if (ped_pend !== 4'b1010) begin fails++; $display("FAIL west_latch got %b want 1010", ped_pend); end
        for (int i = 0; i < 6; i++) begin
            do_tick();
            tests++; if (phase_a !== 3'(pa[i])) begin fails++; $display("FAIL west_phase_a k=%0d got %0d want %0d", i + 2, phase_a, pa[i]); end
        end
        tests++; if (walk_a !== 2'b10) begin fails++; $display("FAIL west_walk_a got %b want 10", walk_a); end
        tests++; if (ped_pend !== 4'b1000) begin fails++; $display("FAIL west_pend got %b want 1000", ped_pend); end
    endtask

    task automatic test_west_floor();
        apply_reset();
        repeat (4) do_tick();
        tests++; if (phase_a !== 3'd0) begin fails++; $display("FAIL floor_pre_phase got %0d want 0", phase_a); end
        press_west();
        do_tick();
        tests++; if (phase_a !== 3'd1) begin fails++; $display("FAIL floor_phase_a got %0d want 1", phase_a); end
        tests++; if (sec_left_a !== 6'd2) begin fails++; $display("FAIL floor_sec_a got %0d want 2", sec_left_a); end
    endtask

    task automatic test_reset_mid_walk();
        apply_reset();
        press_nrth();
        do_tick();
        tests++; if (walk_a !== 2'b01) begin fails++; $display("FAIL midwalk_pre_walk got %b want 01", walk_a); end
        tests++; if (ped_pend !== 4'b0100) begin fails++; $display("FAIL midwalk_pre_pend got %b want 0100", ped_pend); end
        @(negedge clk_50_mhz); reset = 1'b1; tick_1hz = 1'b1;
        @(negedge clk_50_mhz); reset = 1'b0; tick_1hz = 1'b0;
        tests++; if ({phase_b, phase_a} !== 6'o55) begin fails++; $display("FAIL midwalk_phases got %0d/%0d want 5/5", phase_a, phase_b); end
        tests++; if ({walk_b, walk_a} !== 4'b0) begin fails++; $display("FAIL midwalk_walk got %b want 0000", {walk_b, walk_a}); end
        tests++; if (ped_pend !== 4'b0) begin fails++; $display("FAIL midwalk_pend got %b want 0000", ped_pend); end
        tests++; if (sec_left_a !== 6'd1) begin fails++; $display("FAIL midwalk_sec got %0d want 1", sec_left_a); end
    endtask

    task automatic test_hold_and_walk_ignore();
        apply_reset();
        @(negedge clk_50_mhz); ped_req_nrth = 1'b1;
        @(negedge clk_50_mhz);
        tests++; if (ped_pend !== 4'b0101) begin fails++; $display("FAIL hold_latch got %b want 0101", ped_pend); end
        repeat (20) do_tick();
        tests++; if (phase_a !== 3'd0) begin fails++; $display("FAIL hold_phase_a got %0d want 0", phase_a); end
        tests++; if ({walk_b, walk_a} !== 4'b0) begin fails++; $display("FAIL hold_walk got %b want 0000", {walk_b, walk_a}); end
        tests++; if (ped_pend !== 4'b0) begin fails++; $display("FAIL hold_pend got %b want 0000", ped_pend); end
        ped_req_nrth = 1'b0;

        apply_reset();
        press_nrth();
        do_tick();
        tests++; if (ped_pend !== 4'b0100) begin fails++; $display("FAIL ign_grant_pend got %b want 0100", ped_pend); end
        press_nrth();
        tests++; if (ped_pend !== 4'b0100) begin fails++; $display("FAIL ign_a_walking got %b want 0100", ped_pend); end
        do_tick();
        do_tick();
        tests++; if ({walk_b, walk_a} !== 4'b0100) begin fails++; $display("FAIL ign_walks got %b want 0100", {walk_b, walk_a}); end
        tests++; if (ped_pend !== 4'b0000) begin fails++; $display("FAIL ign_b_grant_pend got %b want 0000", ped_pend); end
        press_nrth();
        tests++; if (ped_pend !== 4'b0001) begin fails++; $display("FAIL ign_b_walking got %b want 0001", ped_pend); end
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_north_ped();
        test_west_early();
        test_west_floor();
        test_reset_mid_walk();
        test_hold_and_walk_ignore();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
